// File: rtl/uart_out_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_out_serializer_pkg
// Description : Shared types, widths and helpers for the UART output
//               serializer and its word FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_out_serializer_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int MIN_BYTE_GAP   = 3;

    // FIFO entry is {size, data}: size=1 means all four bytes are sent.
    localparam int ENTRY_W = WORD_W + 1;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_GAP   = 2'd2
    } seq_state_e;

    localparam logic [1:0] c_ST_IDLE  = SEQ_IDLE;
    localparam logic [1:0] c_ST_ISSUE = SEQ_ISSUE;
    localparam logic [1:0] c_ST_GAP   = SEQ_GAP;

    // Pick byte lane idx of a word; msb_first reverses the lane order.
    function automatic logic [BYTE_W-1:0] sel_byte(
        input logic [WORD_W-1:0] word,
        input logic [1:0]        idx,
        input logic              msb_first
    );
        logic [1:0] lane;
        lane = msb_first ? (2'd3 - idx) : idx;
        return word[lane*BYTE_W +: BYTE_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_out_serializer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : out_word_fifo
// Description : Synchronous single-clock FIFO holding {size, data} output
//               words. Read data is the current head (show-ahead).
// Revision    : 1.0 - initial release
// ============================================================================
module out_word_fifo
    import uart_out_serializer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_1 = (c_PTR_W)'(1);

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PTR_W:0]   r_count_q,  w_count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count_q == c_FULL);
    assign o_empty   = (r_count_q == '0);
    assign o_count   = r_count_q;
    assign o_rdata   = r_mem_q[r_rd_ptr_q];

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Next pointer and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_do_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_1;
        end
        if (w_do_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_d = r_count_q + (c_PTR_W+1)'(1);
            2'b01:   w_count_d = r_count_q - (c_PTR_W+1)'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wr_ptr_q] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_out_serializer
// Description : Buffers 8/32-bit core output requests and emits single-cycle
//               byte strobes to the UART transmit top, spaced BYTE_GAP cycles
//               apart so its idle/wait/wrote accept sequence is never violated.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_out_serializer
    import uart_out_serializer_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int BYTE_GAP  = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              out_valid,
    input  logic              out_size,
    input  logic [WORD_W-1:0] out_data,
    output logic              out_ready,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    output logic              busy
);

    localparam int               c_GAP_W    = $clog2(BYTE_GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = (c_GAP_W)'(BYTE_GAP - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE  = (c_GAP_W)'(1);
    localparam logic               c_MSB      = (MSB_FIRST != 0);

    // Parameter sanity checks at elaboration.
    generate
        if (BYTE_GAP < MIN_BYTE_GAP) begin : g_gap_check
            $error("uart_out_serializer: BYTE_GAP must be at least MIN_BYTE_GAP");
        end
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("uart_out_serializer: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [ENTRY_W-1:0]     w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_push;
    logic                   w_pop;

    logic [1:0]        r_state_q,   w_state_d;
    logic [WORD_W-1:0] r_word_q,    w_word_d;
    logic              r_size_q,    w_size_d;
    logic [2:0]        r_nbytes_q,  w_nbytes_d;
    logic [2:0]        r_idx_q,     w_idx_d;
    logic [c_GAP_W-1:0] r_gap_q,    w_gap_d;
    logic [BYTE_W-1:0] r_tx_data_q, w_tx_data_d;

    // Ready comes from the registered count only, so it has no input path.
    assign out_ready = !w_full;
    assign w_push    = out_valid && out_ready;

    out_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({out_size, out_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Sequencer: pop a word in IDLE, strobe one byte per ISSUE, pad with GAP.
    // tx_data is loaded on the transition into ISSUE so it changes only in
    // the strobe cycle and holds otherwise.
    always_comb begin
        w_state_d   = r_state_q;
        w_word_d    = r_word_q;
        w_size_d    = r_size_q;
        w_nbytes_d  = r_nbytes_q;
        w_idx_d     = r_idx_q;
        w_gap_d     = r_gap_q;
        w_tx_data_d = r_tx_data_q;
        w_pop       = 1'b0;
        case (r_state_q)
            c_ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_word_d    = w_head[WORD_W-1:0];
                    w_size_d    = w_head[WORD_W];
                    w_nbytes_d  = w_head[WORD_W] ? 3'd4 : 3'd1;
                    w_idx_d     = 3'd0;
                    // Byte-size entries always send data[7:0].
                    w_tx_data_d = sel_byte(w_head[WORD_W-1:0], 2'd0,
                                           c_MSB && w_head[WORD_W]);
                    w_state_d   = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_idx_d   = r_idx_q + 3'd1;
                w_gap_d   = c_GAP_LOAD;
                w_state_d = c_ST_GAP;
            end
            c_ST_GAP: begin
                w_gap_d = r_gap_q - c_GAP_ONE;
                if (r_gap_q == c_GAP_ONE) begin
                    if (r_idx_q < r_nbytes_q) begin
                        w_tx_data_d = sel_byte(r_word_q, r_idx_q[1:0],
                                               c_MSB && r_size_q);
                        w_state_d   = c_ST_ISSUE;
                    end else begin
                        w_state_d   = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= c_ST_IDLE;
            r_word_q    <= '0;
            r_size_q    <= 1'b0;
            r_nbytes_q  <= 3'd0;
            r_idx_q     <= 3'd0;
            r_gap_q     <= '0;
            r_tx_data_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_word_q    <= w_word_d;
            r_size_q    <= w_size_d;
            r_nbytes_q  <= w_nbytes_d;
            r_idx_q     <= w_idx_d;
            r_gap_q     <= w_gap_d;
            r_tx_data_q <= w_tx_data_d;
        end
    end

    assign tx_start = (r_state_q == c_ST_ISSUE);
    assign tx_data  = r_tx_data_q;
    assign busy     = (w_count != '0) || (r_state_q != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_out_serializer
// Description : Scoreboard bench for uart_out_serializer. Two instances
//               (LSB-first and MSB-first) share the same stimulus; a
//               behavioural model predicts every strobe cycle and byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_out_serializer;

    localparam int DEPTH    = 8;
    localparam int BYTE_GAP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_valid = 1'b0;
    logic        out_size = 1'b0;
    logic [31:0] out_data = '0;

    logic        ready_a, start_a, busy_a;
    logic [7:0]  data_a;
    logic        ready_b, start_b, busy_b;
    logic [7:0]  data_b;

    always #5 clk = ~clk;

    uart_out_serializer #(.DEPTH(DEPTH), .BYTE_GAP(BYTE_GAP), .MSB_FIRST(0)) u_dut_lsb (
        .clk(clk), .rst(rst), .out_valid(out_valid), .out_size(out_size),
        .out_data(out_data), .out_ready(ready_a), .tx_start(start_a),
        .tx_data(data_a), .busy(busy_a)
    );

    uart_out_serializer #(.DEPTH(DEPTH), .BYTE_GAP(BYTE_GAP), .MSB_FIRST(1)) u_dut_msb (
        .clk(clk), .rst(rst), .out_valid(out_valid), .out_size(out_size),
        .out_data(out_data), .out_ready(ready_b), .tx_start(start_b),
        .tx_data(data_b), .busy(busy_b)
    );

    // One expected byte: values for both byte orders, whether it opens a
    // word, and the cycle its word was accepted.
    typedef struct {
        logic [7:0] da;
        logic [7:0] db;
        bit         first;
        int         acc;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_cyc = 0;
    bit         have_last = 1'b0;
    int         mcount = 0;
    logic [7:0] hold_a = '0;
    logic [7:0] hold_b = '0;
    bit         acc_flag = 1'b0;
    bit         model_busy = 1'b0;
    int         nstrobe = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor + reference model, evaluated mid-cycle.
    always @(negedge clk) begin : p_monitor
        bit         es;
        int         due;
        bit         er;
        bit         eb;
        int         n;
        exp_t       e;
        es  = 1'b0;
        due = -1;
        if (sbq.size() > 0) begin
            if (sbq[0].first) begin
                due = sbq[0].acc + 2;
                if (have_last && (last_cyc + BYTE_GAP + 1 > due))
                    due = last_cyc + BYTE_GAP + 1;
            end else begin
                due = last_cyc + BYTE_GAP;
            end
            es = (cyc == due);
        end
        if (es) begin
            e = sbq.pop_front();
            if (e.first) mcount--;
            hold_a    = e.da;
            hold_b    = e.db;
            last_cyc  = cyc;
            have_last = 1'b1;
            nstrobe++;
        end
        chk("tx_start_lsb", {31'd0, start_a}, {31'd0, es});
        chk("tx_start_msb", {31'd0, start_b}, {31'd0, es});
        chk("tx_data_lsb", {24'd0, data_a}, {24'd0, hold_a});
        chk("tx_data_msb", {24'd0, data_b}, {24'd0, hold_b});
        er = (mcount < DEPTH);
        chk("out_ready_lsb", {31'd0, ready_a}, {31'd0, er});
        chk("out_ready_msb", {31'd0, ready_b}, {31'd0, er});
        eb = (sbq.size() > 0) || (have_last && (cyc - last_cyc < BYTE_GAP));
        chk("busy_lsb", {31'd0, busy_a}, {31'd0, eb});
        chk("busy_msb", {31'd0, busy_b}, {31'd0, eb});
        if (!rst && out_valid && er) begin
            n = out_size ? 4 : 1;
            for (int i = 0; i < n; i++) begin
                e.da    = out_data[8*i +: 8];
                e.db    = out_size ? out_data[8*(3-i) +: 8] : out_data[7:0];
                e.first = (i == 0);
                e.acc   = cyc;
                sbq.push_back(e);
            end
            mcount++;
            acc_flag = 1'b1;
            eb = 1'b1;
        end
        if (rst) begin
            sbq.delete();
            mcount    = 0;
            have_last = 1'b0;
            hold_a    = '0;
            hold_b    = '0;
            eb        = 1'b0;
        end
        model_busy = eb;
        cyc++;
    end

    task automatic push_word(input logic sz, input logic [31:0] d);
        int n;
        @(posedge clk); #1;
        out_valid = 1'b1;
        out_size  = sz;
        out_data  = d;
        acc_flag  = 1'b0;
        n = 0;
        forever begin
            @(negedge clk); #1;
            if (acc_flag) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL push_timeout cyc=%0d actual=not_accepted required=accepted", cyc);
                break;
            end
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        @(posedge clk); #1;
        out_valid = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk); #1;
            if (!model_busy) return;
        end
        checks++; errors++;
        $display("FAIL idle_timeout cyc=%0d actual=busy required=idle", cyc);
    endtask

    initial begin : p_stim
        int base;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        push_word(1'b0, 32'h0000_00A5);
        wait_idle(50);
        push_word(1'b1, 32'h1122_3344);
        wait_idle(50);
        push_word(1'b1, 32'hDEAD_BEEF);
        push_word(1'b1, 32'h0102_0304);
        wait_idle(100);

        // Burst deep enough to fill the FIFO and stall the core.
        for (int i = 0; i < 10; i++) push_word(1'b1, 32'hA000_0000 + i * 32'h0101_0101);
        wait_idle(600);

        // Reset right after the second byte of a word.
        base = nstrobe;
        push_word(1'b1, 32'hCAFE_BABE);
        @(posedge clk); #1 out_valid = 1'b0;
        n = 0;
        while (nstrobe < base + 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        push_word(1'b0, 32'h0000_007E);
        wait_idle(50);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            out_valid = ($urandom_range(0, 2) != 0);
            out_size  = $urandom_range(0, 1) != 0;
            out_data  = $urandom;
        end
        wait_idle(2000);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
